// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the convolution datapath.
package cnn_pkg;

    localparam int CONV_DW   = 10;
    localparam int MAP_W_DEF = 4;
    localparam int MAP_H_DEF = 4;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/signed_max2.sv
// Combinational signed maximum of two operands.
module signed_max2 #(
    parameter int DW = 10
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] y
);

    // On a tie either operand is the same value, so b is returned.
    always_comb begin
        y = (a > b) ? a : b;
    end

endmodule

// File: rtl/conv_maxpool.sv
// 2x2 stride-2 max pooling over a raster-ordered feature-map stream.
module conv_maxpool
    import cnn_pkg::*;
#(
    parameter int DW    = CONV_DW,
    parameter int MAP_W = MAP_W_DEF,
    parameter int MAP_H = MAP_H_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    input  logic                 out_ready,
    output logic                 frame_done
);

    localparam int          CW = cnt_w(MAP_W);
    localparam int          RW = cnt_w(MAP_H);
    localparam int unsigned LB = MAP_W / 2;
    localparam int          IW = cnt_w(MAP_W / 2);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic signed [DW-1:0] pair_q, pair_d;
    logic signed [DW-1:0] lb_q [LB];
    logic signed [DW-1:0] lb_d [LB];
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] out_data_q, out_data_d;
    logic                 frame_done_q, frame_done_d;

    logic [IW-1:0]        pidx;
    logic signed [DW-1:0] h_max;
    logic signed [DW-1:0] v_max;
    logic                 accept;
    logic                 last_col;
    logic                 last_row;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready && !clear;
    assign pidx       = IW'(col_q >> 1);
    assign last_col   = (col_q == CW'(MAP_W - 1));
    assign last_row   = (row_q == RW'(MAP_H - 1));
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

    signed_max2 #(.DW(DW)) u_hmax (
        .a (pair_q),
        .b (in_data),
        .y (h_max)
    );

    signed_max2 #(.DW(DW)) u_vmax (
        .a (lb_q[pidx]),
        .b (h_max),
        .y (v_max)
    );

    // Next-state: raster counters, pair/line buffering and output handshake.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        lb_d         = lb_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;

        if (clear) begin
            col_d       = '0;
            row_d       = '0;
            pair_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                col_d = last_col ? '0 : col_q + 1'b1;
                if (last_col) begin
                    row_d = last_row ? '0 : row_q + 1'b1;
                end
                if (!col_q[0]) begin
                    pair_d = in_data;
                end else if (!row_q[0]) begin
                    lb_d[pidx] = h_max;
                end else begin
                    out_data_d   = v_max;
                    out_valid_d  = 1'b1;
                    frame_done_d = last_row && last_col;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            for (int unsigned i = 0; i < LB; i++) begin
                lb_q[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            lb_q         <= lb_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench for conv_maxpool (4x4 map, 10-bit samples).
module tb_conv_maxpool;

    localparam int DW = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clear;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_ready;
    logic                 frame_done;

    int total = 0;
    int bad   = 0;

    int exp_data[$];
    bit exp_done[$];

    conv_maxpool #(.DW(DW), .MAP_W(4), .MAP_H(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s act=%0d req=%0d", nm, act, req);
        end
    endtask

    // Monitor: pop on each newly presented output, check hold while stalled.
    bit fresh = 1'b1;
    int held  = 0;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (fresh) begin
                if (exp_data.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out act=%0d req=none", int'(out_data));
                end else begin
                    held = exp_data.pop_front();
                    chk("out_data", int'(out_data), held);
                    chk("frame_done", int'(frame_done), int'(exp_done.pop_front()));
                end
            end else begin
                chk("hold_data", int'(out_data), held);
                chk("done_stall", int'(frame_done), 0);
            end
        end
        fresh = !(rst_n && out_valid && !out_ready);
    end

    // Present one sample, optionally pushing the pooled value it completes.
    task automatic send(input int v, input bit pe, input int ev, input bit ed);
        int n;
        if (pe) begin
            exp_data.push_back(ev);
            exp_done.push_back(ed);
        end
        in_valid = 1'b1;
        in_data  = DW'(v);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic ramp(input bit bubbles);
        for (int k = 1; k <= 16; k++) begin
            send(k, (k == 6) || (k == 8) || (k == 14) || (k == 16), k, k == 16);
            if (bubbles) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame.
        ramp(1'b0);

        // Signed values and ties, then restart the frame with clear.
        send(-3, 0, 0, 0);
        send(-3, 0, 0, 0);
        send(0, 0, 0, 0);
        send(-512, 0, 0, 0);
        send(-3, 0, 0, 0);
        send(-4, 1, -3, 0);
        send(511, 0, 0, 0);
        send(511, 1, 511, 0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;

        // Backpressure: stall 5 cycles on the first pooled value.
        for (int k = 1; k <= 5; k++) send(k, 0, 0, 0);
        out_ready = 1'b0;
        send(6, 1, 6, 0);
        in_valid = 1'b1;
        in_data  = DW'(7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int k = 7; k <= 16; k++)
            send(k, (k == 8) || (k == 14) || (k == 16), k, k == 16);

        // Bubbles, then two back-to-back frames.
        ramp(1'b1);
        ramp(1'b0);
        ramp(1'b0);

        // Clear after sample 7; the sample presented with clear is dropped.
        for (int k = 1; k <= 7; k++) send(k, k == 6, k, 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(99);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        ramp(1'b0);

        // Reset mid-frame while a pooled value is showing.
        for (int k = 1; k <= 5; k++) send(k, 0, 0, 0);
        send(6, 0, 0, 0);
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_data", int'(out_data), 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_done", int'(frame_done), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ramp(1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int c = 0; c < 100 && exp_data.size() != 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_data.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
